dfr_axil_master: RTL and testbench
==================================

Name: dfr_axil_master

Overview:
- AXI4-Lite initiator (master) that drives the DFR core's AXI-Lite slave port from a simple command interface.
- Used by on-chip test sequencers and bring-up logic to:
  - load config registers and the input/weight memory windows;
  - set ctrl[0];
  - read back debug, status and DFR output memory.
- Each command is a run of 1..256 single-beat AXI-Lite transactions at incrementing addresses, streaming write data in or read data out.
- One outstanding transaction at a time.

Parameters:
- C_M_AXI_ADDR_WIDTH, 30, AXI address width (matches the core's slave).
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_STRIDE, 4, address increment between beats, in bytes.

Ports:
- M_AXI_ACLK  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted (high only in IDLE)
- cmd_write  in  1  1 = write run, 0 = read run
- cmd_addr  in  30  byte address of first beat
- cmd_len  in  8  number of beats minus 1
- wr_data  in  32  write beat data
- wr_valid  in  1  write data offered
- wr_ready  out  1  write data taken
- rd_data  out  32  read beat data
- rd_valid  out  1  read data available
- rd_ready  in  1  read data consumed
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky: some beat in the current run returned a non-OKAY response
- err_resp  out  2  response code of the first failing beat
- err_beat  out  8  index of the first failing beat
- M_AXI_AWADDR out 30; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
- M_AXI_ARADDR out 30; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

Behaviour:
- Reset (async, any state):
  - state goes to IDLE;
  - all AXI valid/ready outputs, addresses, WDATA, rd_data, rd_valid, wr_ready, busy, done, err, err_resp, err_beat all go to 0.
  - cmd_ready = 1 from the first clock after reset deasserts.
  - Reset mid-run abandons the transaction; dropping VALID is permitted because this block shares the system reset with the slave.
- States: IDLE, W_FETCH, W_ISSUE, W_RESP, R_ISSUE, R_DATA, R_OUT, DONE.
- IDLE: on cmd_valid & cmd_ready:
  - latch addr, len and dir; beat = 0;
  - clear err, err_resp and err_beat;
  - go to W_FETCH or R_ISSUE.
- W_FETCH: wr_ready = 1; on wr_valid, latch WDATA and go to W_ISSUE.
- W_ISSUE:
  - AWVALID and WVALID both rise on entry.
  - Each deasserts independently on its own handshake, tracked with aw_done/w_done flags.
  - AWADDR and WDATA stay stable while the corresponding valid is high.
  - When both handshakes are complete (same or different cycles), go to W_RESP.
- W_RESP: BREADY = 1; on BVALID, check BRESP, then advance the beat.
- R_ISSUE: ARVALID = 1 until ARREADY, then go to R_DATA.
- R_DATA: RREADY = 1; on RVALID, latch RDATA into rd_data, check RRESP, go to R_OUT.
- R_OUT:
  - rd_valid = 1, with rd_data held, until rd_ready; then advance the beat.
  - RREADY is never high here, so the holding register is never overwritten.
- Advance beat: if beat == len, go to DONE; else beat += 1, addr += ADDR_STRIDE (modulo 2^30, wraps silently), and return to W_FETCH or R_ISSUE.
- DONE: done = 1 for exactly one cycle, then IDLE; cmd_ready = 1 on the following cycle.
- Response check: RESP != 0 with err == 0 sets err = 1, err_resp = RESP, err_beat = beat. The run always continues to completion; later errors do not overwrite the first.
- M_AXI_WSTRB is constant 4'hF.
- Throughput with zero-wait slave: write beat ≥ 3 cycles, read beat ≥ 3 cycles; no overlap between beats.
- cmd_valid while busy: ignored (cmd_ready = 0).
- wr_valid outside W_FETCH: ignored (wr_ready = 0).
- cmd_len = 0: single beat.
- cmd_len = 255: 256 beats, and the beat counter must not overflow before the compare.

Decomposition:
- Package dfr_axil_pkg holds:
  - state enum;
  - AXI response constants (RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11);
  - WSTRB_ALL = 4'hF.
- The beat index reuses the existing `counter` module (en = advance, rst = rst | accept).
- No other sub-module is needed.

Test Plan:
- Single write, addr 0x0000_0004, data 0xDEAD_BEEF, zero-wait slave -> one AW+W handshake at addr 0x4 with WSTRB = F, BREADY seen, done pulses once, err = 0.
- Write run len = 3 at 0x0040_0000, slave delays AWREADY 2 cycles and WREADY 0 cycles -> WVALID drops first, AWVALID holds, addresses 0x0040_0000/04/08/0C in order, 4 B handshakes.
- Read run len = 1 at 0x0080_0000, rd_ready held low 5 cycles on beat 0 -> RREADY stays low, rd_data stable, second ARVALID only after rd_ready; returned data matches the slave model.
- Read run len = 2 with beat 1 RRESP = SLVERR and beat 2 RRESP = DECERR -> err = 1, err_resp = 2'b10, err_beat = 1, all 3 beats delivered, done pulses.
- Reset asserted during W_ISSUE with AWVALID high -> all valids 0 asynchronously, busy = 0, cmd_ready = 1 after release; a new command then completes normally.
- cmd_addr = 0x3FFF_FFFC, len = 1 -> second beat addr wraps to 0x0000_0000.

Source files
------------

// File: rtl/dfr_axil_pkg.sv
`default_nettype none
//============================================================================
// Module : dfr_axil_pkg
// Brief  : Shared types and constants for the DFR AXI4-Lite command master.
// Rev    : 1.0 - initial release
//============================================================================
package dfr_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_FETCH = 3'd1,
        ST_W_ISSUE = 3'd2,
        ST_W_RESP  = 3'd3,
        ST_R_ISSUE = 3'd4,
        ST_R_DATA  = 3'd5,
        ST_R_OUT   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] WSTRB_ALL = 4'hF;

    // EXOKAY has no meaning on AXI-Lite, so anything but OKAY is a failed beat.
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic r;
        case (resp)
            RESP_OKAY:                             r = 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: r = 1'b1;
            default:                               r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfr_axil_master_if.sv
`default_nettype none
//============================================================================
// Module : dfr_axil_master_if
// Brief  : Command/stream side plus AXI4-Lite bus of the DFR command master.
// Rev    : 1.0 - initial release
//============================================================================
interface dfr_axil_master_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [7:0]              cmd_len;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [1:0]              err_resp;
    logic [7:0]              err_beat;

    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err, err_resp, err_beat,
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err, err_resp, err_beat,
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

endinterface
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
//============================================================================
// Module : counter
// Brief  : Free-running up counter with synchronous clear and enable.
// Rev    : 1.0 - initial release
//============================================================================
module counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    output logic [WIDTH-1:0]      count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dfr_axil_master.sv
`default_nettype none
//============================================================================
// Module : dfr_axil_master
// Brief  : AXI4-Lite master issuing runs of single-beat transfers from a command port.
// Rev    : 1.0 - initial release
//============================================================================
import dfr_axil_pkg::*;

module dfr_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int ADDR_STRIDE        = 4
) (
    input  wire logic           M_AXI_ACLK,
    input  wire logic           rst,
    dfr_axil_master_if.master   bus
);

    state_t                          r_state;
    state_t                          w_next_state;
    logic [7:0]                      w_beat;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]                      r_len;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rd_data;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic                            r_out_of_reset;
    logic                            r_err;
    logic [1:0]                      r_err_resp;
    logic [7:0]                      r_err_beat;

    logic       w_accept, w_wr_take, w_awvalid, w_wvalid, w_aw_hs, w_w_hs;
    logic       w_b_hs, w_r_hs, w_rd_take, w_advance, w_last, w_resp_valid;
    logic [1:0] w_resp;

    assign w_accept     = bus.cmd_valid & bus.cmd_ready;
    assign w_wr_take    = (r_state == ST_W_FETCH) & bus.wr_valid;
    assign w_awvalid    = (r_state == ST_W_ISSUE) & ~r_aw_done;
    assign w_wvalid     = (r_state == ST_W_ISSUE) & ~r_w_done;
    assign w_aw_hs      = w_awvalid & bus.M_AXI_AWREADY;
    assign w_w_hs       = w_wvalid & bus.M_AXI_WREADY;
    assign w_b_hs       = (r_state == ST_W_RESP) & bus.M_AXI_BVALID;
    assign w_r_hs       = (r_state == ST_R_DATA) & bus.M_AXI_RVALID;
    assign w_rd_take    = (r_state == ST_R_OUT) & bus.rd_ready;
    assign w_advance    = w_b_hs | w_rd_take;
    assign w_last       = (w_beat == r_len);
    assign w_resp_valid = w_b_hs | w_r_hs;
    assign w_resp       = w_b_hs ? bus.M_AXI_BRESP : bus.M_AXI_RRESP;

    // Beat index is cleared on every accepted command, so it always starts at 0.
    counter #(.WIDTH(8)) u_beat (
        .clk   (M_AXI_ACLK),
        .rst   (rst | w_accept),
        .en    (w_advance),
        .count (w_beat)
    );

    always_ff @(posedge M_AXI_ACLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next_state = bus.cmd_write ? ST_W_FETCH : ST_R_ISSUE;
            ST_W_FETCH: if (bus.wr_valid) w_next_state = ST_W_ISSUE;
            ST_W_ISSUE: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_next_state = ST_W_RESP;
            ST_W_RESP:  if (w_b_hs) w_next_state = w_last ? ST_DONE : ST_W_FETCH;
            ST_R_ISSUE: if (bus.M_AXI_ARREADY) w_next_state = ST_R_DATA;
            ST_R_DATA:  if (bus.M_AXI_RVALID) w_next_state = ST_R_OUT;
            ST_R_OUT:   if (bus.rd_ready) w_next_state = w_last ? ST_DONE : ST_R_ISSUE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_len          <= '0;
            r_wdata        <= '0;
            r_rd_data      <= '0;
            r_aw_done      <= 1'b0;
            r_w_done       <= 1'b0;
            r_out_of_reset <= 1'b0;
            r_err          <= 1'b0;
            r_err_resp     <= '0;
            r_err_beat     <= '0;
        end else begin
            r_out_of_reset <= 1'b1;
            if (w_accept) begin
                r_addr     <= bus.cmd_addr;
                r_len      <= bus.cmd_len;
                r_err      <= 1'b0;
                r_err_resp <= '0;
                r_err_beat <= '0;
            end
            if (w_wr_take) begin
                r_wdata   <= bus.wr_data;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_r_hs)  r_rd_data <= bus.M_AXI_RDATA;
            // Only the first failing beat of a run is recorded.
            if (w_resp_valid && resp_is_error(w_resp) && !r_err) begin
                r_err      <= 1'b1;
                r_err_resp <= w_resp;
                r_err_beat <= w_beat;
            end
            if (w_advance && !w_last) begin
                r_addr <= r_addr + C_M_AXI_ADDR_WIDTH'(ADDR_STRIDE);
            end
        end
    end

    assign bus.cmd_ready     = r_out_of_reset & (r_state == ST_IDLE);
    assign bus.wr_ready      = (r_state == ST_W_FETCH);
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_valid      = (r_state == ST_R_OUT);
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.err           = r_err;
    assign bus.err_resp      = r_err_resp;
    assign bus.err_beat      = r_err_beat;

    assign bus.M_AXI_AWADDR  = r_addr;
    assign bus.M_AXI_AWVALID = w_awvalid;
    assign bus.M_AXI_WDATA   = r_wdata;
    assign bus.M_AXI_WSTRB   = WSTRB_ALL;
    assign bus.M_AXI_WVALID  = w_wvalid;
    assign bus.M_AXI_BREADY  = (r_state == ST_W_RESP);
    assign bus.M_AXI_ARADDR  = r_addr;
    assign bus.M_AXI_ARVALID = (r_state == ST_R_ISSUE);
    assign bus.M_AXI_RREADY  = (r_state == ST_R_DATA);

endmodule
`default_nettype wire

// File: tb/tb_dfr_axil_master.sv
`default_nettype none
//============================================================================
// Module : tb_dfr_axil_master
// Brief  : Self-checking bench: AXI-Lite slave model plus command/stream driver.
// Rev    : 1.0 - initial release
//============================================================================
module tb_dfr_axil_master;
    import dfr_axil_pkg::*;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dfr_axil_master_if #(.ADDR_WIDTH(30), .DATA_WIDTH(32)) bus ();

    dfr_axil_master #(
        .C_M_AXI_ADDR_WIDTH (30),
        .C_M_AXI_DATA_WIDTH (32),
        .ADDR_STRIDE        (4)
    ) dut (
        .M_AXI_ACLK (clk),
        .rst        (rst),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=no_event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } wexp_t;

    wexp_t       exp_wq[$];
    logic [29:0] exp_arq[$];
    logic [31:0] exp_rq[$];

    int         aw_dly, w_dly, bad_a, bad_b, s_beat, b_count, r_count;
    logic [1:0] resp_a, resp_b;

    function automatic logic [31:0] rd_pattern(input logic [29:0] a);
        return {2'b10, a} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [1:0] resp_for(input int beat);
        if (beat == bad_a) return resp_a;
        if (beat == bad_b) return resp_b;
        return RESP_OKAY;
    endfunction

    // Slave model: decisions made mid-cycle, handshakes retired on the next pass.
    initial begin : slave
        bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit          got_aw, got_w, b_pend, r_pend;
        logic [29:0] aw_a, ar_a;
        logic [31:0] w_d;
        int          aw_cnt, w_cnt;
        wexp_t       e;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, b_pend, r_pend} = '0;
        aw_cnt = 0; w_cnt = 0; aw_a = '0; ar_a = '0; w_d = '0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        bus.M_AXI_BRESP = 0; bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
        bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
        forever begin
            tick();
            if (rst) begin
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, b_pend, r_pend} = '0;
                aw_cnt = 0; w_cnt = 0;
                bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
                bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
                continue;
            end
            if (aw_hs) got_aw = 1;
            if (w_hs)  got_w  = 1;
            if (got_aw && got_w) begin
                if (exp_wq.size() == 0) fail_msg("w_extra_beat");
                else begin
                    e = exp_wq.pop_front();
                    check("aw_addr", aw_a, e.addr);
                    check("w_data", w_d, e.data);
                end
                got_aw = 0; got_w = 0; b_pend = 1;
            end
            if (b_hs) begin b_pend = 0; s_beat++; b_count++; end
            if (ar_hs) begin
                r_pend = 1;
                if (exp_arq.size() == 0) fail_msg("ar_extra_beat");
                else check("ar_addr", ar_a, exp_arq.pop_front());
            end
            if (r_hs) begin r_pend = 0; s_beat++; r_count++; end

            if (bus.M_AXI_AWVALID && got_aw) fail_msg("awvalid_after_hs");
            if (bus.M_AXI_WVALID && got_w)   fail_msg("wvalid_after_hs");
            if (bus.M_AXI_ARVALID && r_pend) fail_msg("arvalid_while_pending");

            bus.M_AXI_AWREADY = 0;
            if (bus.M_AXI_AWVALID && !got_aw) begin
                bus.M_AXI_AWREADY = (aw_cnt >= aw_dly);
                aw_cnt++;
            end
            aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY && !got_aw;
            if (aw_hs) begin aw_a = bus.M_AXI_AWADDR; aw_cnt = 0; end

            bus.M_AXI_WREADY = 0;
            if (bus.M_AXI_WVALID && !got_w) begin
                bus.M_AXI_WREADY = (w_cnt >= w_dly);
                w_cnt++;
            end
            w_hs = bus.M_AXI_WVALID && bus.M_AXI_WREADY && !got_w;
            if (w_hs) begin
                w_d = bus.M_AXI_WDATA; w_cnt = 0;
                check("wstrb", bus.M_AXI_WSTRB, 4'hF);
            end

            bus.M_AXI_BVALID = b_pend;
            bus.M_AXI_BRESP  = b_pend ? resp_for(s_beat) : RESP_OKAY;
            b_hs = b_pend && bus.M_AXI_BREADY;

            bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && !r_pend;
            ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            if (ar_hs) ar_a = bus.M_AXI_ARADDR;

            bus.M_AXI_RVALID = r_pend;
            bus.M_AXI_RDATA  = r_pend ? rd_pattern(ar_a) : 32'h0;
            bus.M_AXI_RRESP  = r_pend ? resp_for(s_beat) : RESP_OKAY;
            r_hs = r_pend && bus.M_AXI_RREADY;
        end
    end

    typedef struct {
        bit          write;
        logic [29:0] addr;
        logic [7:0]  len;
        logic [31:0] d0;
        int          aw_dly;
        int          w_dly;
        int          rd_stall;
        int          bad_a;
        logic [1:0]  resp_a;
        int          bad_b;
        logic [1:0]  resp_b;
        bit          e_err;
        logic [1:0]  e_resp;
        logic [7:0]  e_beat;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    task automatic run_vec(input vec_t v);
        logic [31:0] wdat[$];
        logic [29:0] a;
        logic [31:0] held;
        int          wi, rc, stall, ncyc;
        bit          fin;
        aw_dly = v.aw_dly; w_dly = v.w_dly;
        bad_a = v.bad_a; resp_a = v.resp_a; bad_b = v.bad_b; resp_b = v.resp_b;
        s_beat = 0; b_count = 0; r_count = 0;
        a = v.addr;
        for (int i = 0; i <= int'(v.len); i++) begin
            if (v.write) begin
                wdat.push_back((i == 0) ? v.d0 : $urandom);
                exp_wq.push_back('{a, wdat[i]});
            end else begin
                exp_arq.push_back(a);
                exp_rq.push_back(rd_pattern(a));
            end
            a = a + 30'd4;
        end
        bus.cmd_valid = 1; bus.cmd_write = v.write; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
        ncyc = 0;
        while (!bus.cmd_ready && ncyc < 50) begin tick(); ncyc++; end
        if (!bus.cmd_ready) begin fail_msg("cmd_ready_timeout"); bus.cmd_valid = 0; return; end
        tick();
        check("busy_after_accept", bus.busy, 1'b1);
        // Keep offering a bogus command while busy; it must be ignored.
        bus.cmd_write = ~v.write; bus.cmd_addr = 30'h1555_5554; bus.cmd_len = 8'd7;
        wi = 0; rc = 0; stall = 0; fin = 0; ncyc = 0; held = '0;
        while (!fin && ncyc < 4000) begin
            bus.wr_valid = 1;
            if (bus.wr_ready && wi < wdat.size()) begin bus.wr_data = wdat[wi]; wi++; end
            else bus.wr_data = 32'hBAD0_BAD0;
            bus.rd_ready = 0;
            if (bus.rd_valid) begin
                if (rc == 0 && stall < v.rd_stall) begin
                    if (stall == 0) held = bus.rd_data;
                    else check("rd_data_hold", bus.rd_data, held);
                    check("rready_in_rout", bus.M_AXI_RREADY, 1'b0);
                    check("arvalid_in_rout", bus.M_AXI_ARVALID, 1'b0);
                    stall++;
                end else begin
                    bus.rd_ready = 1;
                    if (exp_rq.size() == 0) fail_msg("rd_extra_beat");
                    else check("rd_data", bus.rd_data, exp_rq.pop_front());
                    rc++;
                end
            end
            if (bus.done) begin
                fin = 1;
                bus.cmd_valid = 0;
                check("err", bus.err, v.e_err);
                check("err_resp", bus.err_resp, v.e_resp);
                check("err_beat", bus.err_beat, v.e_beat);
            end
            tick();
            ncyc++;
        end
        bus.cmd_valid = 0; bus.wr_valid = 0; bus.rd_ready = 0;
        if (!fin) fail_msg("run_timeout");
        check("done_one_cycle", bus.done, 1'b0);
        check("cmd_ready_after_done", bus.cmd_ready, 1'b1);
        check("busy_after_done", bus.busy, 1'b0);
        if (v.write) check("b_count", b_count, int'(v.len) + 1);
        else         check("r_count", r_count, int'(v.len) + 1);
        check("queues_drained", exp_wq.size() + exp_arq.size() + exp_rq.size(), 0);
    endtask

    initial begin : main
        int ncyc;
        rst = 1;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = '0; bus.wr_valid = 0; bus.rd_ready = 0;
        bad_a = -1; bad_b = -1; resp_a = RESP_OKAY; resp_b = RESP_OKAY;
        aw_dly = 0; w_dly = 0; s_beat = 0; b_count = 0; r_count = 0;

        //           wr    addr            len     d0            awd wd st  bad_a resp_a       bad_b resp_b       err   resp   beat
        vecs[0] = '{1'b1, 30'h0000_0004, 8'd0,   32'hDEAD_BEEF, 0, 0, 0, -1,  RESP_OKAY,   -1,  RESP_OKAY,   1'b0, 2'b00, 8'd0};
        vecs[1] = '{1'b1, 30'h0040_0000, 8'd3,   32'h1111_2222, 2, 0, 0, -1,  RESP_OKAY,   -1,  RESP_OKAY,   1'b0, 2'b00, 8'd0};
        vecs[2] = '{1'b0, 30'h0080_0000, 8'd1,   32'h0,         0, 0, 5, -1,  RESP_OKAY,   -1,  RESP_OKAY,   1'b0, 2'b00, 8'd0};
        vecs[3] = '{1'b0, 30'h0000_0100, 8'd2,   32'h0,         0, 0, 0, 1,   RESP_SLVERR, 2,   RESP_DECERR, 1'b1, 2'b10, 8'd1};
        vecs[4] = '{1'b0, 30'h3FFF_FFFC, 8'd1,   32'h0,         0, 0, 0, -1,  RESP_OKAY,   -1,  RESP_OKAY,   1'b0, 2'b00, 8'd0};
        vecs[5] = '{1'b1, 30'h0000_0100, 8'd2,   32'hCAFE_F00D, 0, 3, 0, 0,   RESP_EXOKAY, 2,   RESP_SLVERR, 1'b1, 2'b01, 8'd0};
        vecs[6] = '{1'b1, 30'h0000_1000, 8'd255, 32'h0BAD_CAFE, 1, 1, 0, 255, RESP_DECERR, -1,  RESP_OKAY,   1'b1, 2'b11, 8'd255};
        vecs[7] = '{1'b0, 30'h0000_0020, 8'd0,   32'h0,         0, 0, 0, -1,  RESP_OKAY,   -1,  RESP_OKAY,   1'b0, 2'b00, 8'd0};
        vecs[8] = '{1'b0, 30'h3FFF_F000, 8'd255, 32'h0,         0, 0, 2, 200, RESP_SLVERR, 254, RESP_DECERR, 1'b1, 2'b10, 8'd200};

        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                             bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.wr_ready, bus.rd_valid, bus.done}, 8'h00);
        check("rst_addr", bus.M_AXI_AWADDR, 30'h0);
        check("rst_wdata", bus.M_AXI_WDATA, 32'h0);
        check("rst_rd_data", bus.rd_data, 32'h0);
        check("rst_err", {bus.err, bus.err_resp, bus.err_beat}, 11'h0);
        rst = 0;
        tick();
        check("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset in the middle of W_ISSUE while AWVALID is held by a slow slave.
        aw_dly = 1000; w_dly = 0; bad_a = -1; bad_b = -1; s_beat = 0;
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 30'h0000_2000; bus.cmd_len = 8'd3;
        tick();
        bus.cmd_valid = 0;
        bus.wr_valid = 1; bus.wr_data = 32'h5555_AAAA;
        ncyc = 0;
        while (!bus.M_AXI_AWVALID && ncyc < 20) begin tick(); ncyc++; end
        if (!bus.M_AXI_AWVALID) fail_msg("awvalid_timeout");
        #2 rst = 1;
        #1;
        check("async_rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                   bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 5'h0);
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_cmd_ready", bus.cmd_ready, 1'b0);
        bus.wr_valid = 0;
        repeat (2) tick();
        exp_wq.delete(); exp_arq.delete(); exp_rq.delete();
        rst = 0;
        tick();
        check("cmd_ready_after_rerst", bus.cmd_ready, 1'b1);
        check("busy_after_rerst", bus.busy, 1'b0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
